// File: rtl/mem_access_if.sv
// Data-memory port bundle for the memory stage: req/gnt/rvalid handshake.
// master drives req/we/addr/be/wdata; slave returns gnt/rvalid/rdata.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory stage: owns the EX/MEM and MEM/WB registers and drives the data-memory
// port (req/gnt/rvalid) with byte enables, lane-replicated store data and
// load-data extension. Stalls upstream while an access is outstanding.
// Ports: clk, rst (sync, active high); *_EXE inputs from execute; stall_MEM,
// alu_result_MEM, rd_MEM, reg_write_MEM to hazard/forwarding; dmem (master
// modport of mem_access_if); valid_WB, reg_write_WB, rd_WB, wb_data_WB to
// writeback; misalign_MEM.
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned LH/LHU/SH/LW/SW into traps
// that never reach the memory port.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_EXE,
    input  logic         mem_read_EXE,
    input  logic         mem_write_EXE,
    input  logic         reg_write_EXE,
    input  logic [2:0]   funct3_EXE,
    input  logic [4:0]   rd_EXE,
    input  logic [31:0]  alu_result_EXE,
    input  logic [31:0]  write_data_EXE,
    output logic         stall_MEM,
    output logic [31:0]  alu_result_MEM,
    output logic [4:0]   rd_MEM,
    output logic         reg_write_MEM,
    mem_access_if.master dmem,
    output logic         valid_WB,
    output logic         reg_write_WB,
    output logic [4:0]   rd_WB,
    output logic [31:0]  wb_data_WB,
    output logic         misalign_MEM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    // EX/MEM register
    logic        valid_q;
    logic        rd_en_q;
    logic        wr_en_q;
    logic        rw_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_q;
    logic [31:0] wd_q;

    // MEM/WB register
    logic        wb_valid_q;
    logic        wb_rw_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    logic        advance;
    logic        trap_exe;
    logic        trap_mem;
    logic [31:0] load_ext;
    logic [31:0] wb_data_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

`ifdef MEM_MISALIGN_TRAP_EN
    // Halfword needs a[0]==0, word needs a[1:0]==0; bytes never trap.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign trap_exe = valid_EXE & (mem_read_EXE | mem_write_EXE)
                    & misaligned(funct3_EXE, alu_result_EXE[1:0]);
    assign trap_mem = valid_q & (rd_en_q | wr_en_q)
                    & misaligned(f3_q, alu_q[1:0]);
`else
    assign trap_exe = 1'b0;
    assign trap_mem = 1'b0;
`endif

    assign misalign_MEM = trap_mem;
    assign advance      = ~stall_MEM;

    always_comb begin
        state_d   = state_q;
        stall_MEM = 1'b0;
        case (state_q)
            IDLE: ;
            REQ: begin
                if (dmem.gnt) begin
                    if (!wr_en_q) begin
                        state_d   = RESP;
                        stall_MEM = 1'b1;
                    end
                end else begin
                    stall_MEM = 1'b1;
                end
            end
            RESP: begin
                if (!dmem.rvalid) stall_MEM = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Completion edge chains straight into the next access.
        if (!stall_MEM) begin
            if (valid_EXE & (mem_read_EXE | mem_write_EXE) & ~trap_exe)
                state_d = REQ;
            else
                state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Memory port: all request fields come straight from EX/MEM so they
    // stay stable while waiting for gnt.
    assign dmem.req   = (state_q == REQ);
    assign dmem.we    = wr_en_q;
    assign dmem.addr  = {alu_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        dmem.be    = 4'b1111;
        dmem.wdata = wd_q;
        case (f3_q[1:0])
            2'b00: begin
                dmem.be    = 4'b0001 << alu_q[1:0];
                dmem.wdata = {4{wd_q[7:0]}};
            end
            2'b01: begin
                dmem.be    = 4'b0011 << {alu_q[1], 1'b0};
                dmem.wdata = {2{wd_q[15:0]}};
            end
            default: begin
                dmem.be    = 4'b1111;
                dmem.wdata = wd_q;
            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        ld_byte  = dmem.rdata[7:0];
        ld_half  = alu_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        load_ext = dmem.rdata;
        case (alu_q[1:0])
            2'd0:    ld_byte = dmem.rdata[7:0];
            2'd1:    ld_byte = dmem.rdata[15:8];
            2'd2:    ld_byte = dmem.rdata[23:16];
            default: ld_byte = dmem.rdata[31:24];
        endcase
        case (f3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = dmem.rdata;
        endcase
    end

    assign wb_data_d = (rd_en_q & ~trap_mem) ? load_ext : alu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rw_q       <= 1'b0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            alu_q      <= 32'd0;
            wd_q       <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
        end else if (advance) begin
            valid_q    <= valid_EXE;
            rd_en_q    <= mem_read_EXE;
            wr_en_q    <= mem_write_EXE;
            rw_q       <= reg_write_EXE;
            f3_q       <= funct3_EXE;
            rd_q       <= rd_EXE;
            alu_q      <= alu_result_EXE;
            wd_q       <= write_data_EXE;
            wb_valid_q <= valid_q;
            wb_rw_q    <= rw_q & valid_q & ~trap_mem;
            wb_rd_q    <= rd_q;
            wb_data_q  <= wb_data_d;
        end
    end

    assign alu_result_MEM = alu_q;
    assign rd_MEM         = rd_q;
    assign reg_write_MEM  = rw_q & valid_q;
    assign valid_WB       = wb_valid_q;
    assign reg_write_WB   = wb_rw_q;
    assign rd_WB          = wb_rd_q;
    assign wb_data_WB     = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
// Linear stimulus; each check is an immediate assertion.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_EXE, mem_read_EXE, mem_write_EXE, reg_write_EXE;
    logic [2:0]  funct3_EXE;
    logic [4:0]  rd_EXE;
    logic [31:0] alu_result_EXE, write_data_EXE;
    logic        stall_MEM;
    logic [31:0] alu_result_MEM;
    logic [4:0]  rd_MEM;
    logic        reg_write_MEM;
    logic        valid_WB, reg_write_WB;
    logic [4:0]  rd_WB;
    logic [31:0] wb_data_WB;
    logic        misalign_MEM;

    int vec  = 0;
    int errs = 0;

    mem_access_if #(.ADDR_W(32)) dmem ();

    mem_access #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_EXE      (valid_EXE),
        .mem_read_EXE   (mem_read_EXE),
        .mem_write_EXE  (mem_write_EXE),
        .reg_write_EXE  (reg_write_EXE),
        .funct3_EXE     (funct3_EXE),
        .rd_EXE         (rd_EXE),
        .alu_result_EXE (alu_result_EXE),
        .write_data_EXE (write_data_EXE),
        .stall_MEM      (stall_MEM),
        .alu_result_MEM (alu_result_MEM),
        .rd_MEM         (rd_MEM),
        .reg_write_MEM  (reg_write_MEM),
        .dmem           (dmem),
        .valid_WB       (valid_WB),
        .reg_write_WB   (reg_write_WB),
        .rd_WB          (rd_WB),
        .wb_data_WB     (wb_data_WB),
        .misalign_MEM   (misalign_MEM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic rw, input logic [2:0] f3,
                         input logic [4:0] rdn, input logic [31:0] alu,
                         input logic [31:0] wd);
        valid_EXE      = v;
        mem_read_EXE   = rd;
        mem_write_EXE  = wr;
        reg_write_EXE  = rw;
        funct3_EXE     = f3;
        rd_EXE         = rdn;
        alu_result_EXE = alu;
        write_data_EXE = wd;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // REQ waits two cycles, gnt on the third, one RESP cycle without
    // rvalid, then rvalid: four stall cycles. A stray rvalid during REQ
    // must be ignored.
    task automatic run_load(input logic [2:0] f3, input string nm,
                            input logic [31:0] exp);
        int stalls;
        stalls = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, f3, 5'd5, 32'h0000_2001, 32'd0);
        tick();
        nop();
        check({nm, "_addr"}, dmem.addr, 32'h0000_2000);
        for (int k = 0; k < 5; k++) begin
            dmem.gnt    = (k == 2);
            dmem.rvalid = (k == 1) || (k == 4);
            dmem.rdata  = (k == 4) ? 32'h0000_8000 : 32'hFFFF_FFFF;
            #1;
            check({nm, "_req"}, {31'd0, dmem.req}, {31'd0, k <= 2});
            if (stall_MEM) stalls++;
            tick();
        end
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        check({nm, "_stalls"}, stalls, 32'd4);
        check({nm, "_wb"}, wb_data_WB, exp);
        check({nm, "_rdwb"}, {27'd0, rd_WB}, 32'd5);
        check({nm, "_rwwb"}, {31'd0, reg_write_WB}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'd0;
        nop();
        tick();
        tick();
        check("rst_stall", {31'd0, stall_MEM}, 32'd0);
        check("rst_req", {31'd0, dmem.req}, 32'd0);
        check("rst_vwb", {31'd0, valid_WB}, 32'd0);
        check("rst_wbd", wb_data_WB, 32'd0);
        check("rst_alu", alu_result_MEM, 32'd0);
        check("rst_mis", {31'd0, misalign_MEM}, 32'd0);
        rst = 1'b0;

        // Non-memory ADD
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 5'd7, 32'h55, 32'd0);
        tick();
        nop();
        check("add_aluM", alu_result_MEM, 32'h55);
        check("add_rdM", {27'd0, rd_MEM}, 32'd7);
        check("add_rwM", {31'd0, reg_write_MEM}, 32'd1);
        check("add_req", {31'd0, dmem.req}, 32'd0);
        tick();
        check("add_wb", wb_data_WB, 32'h55);
        check("add_rdwb", {27'd0, rd_WB}, 32'd7);
        check("add_rwwb", {31'd0, reg_write_WB}, 32'd1);
        check("add_req2", {31'd0, dmem.req}, 32'd0);

        // SB at 0x1003, zero-wait grant
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 32'h1003, 32'hA5);
        tick();
        nop();
        dmem.gnt = 1'b1;
        #1;
        check("sb_req", {31'd0, dmem.req}, 32'd1);
        check("sb_we", {31'd0, dmem.we}, 32'd1);
        check("sb_be", {28'd0, dmem.be}, 32'h8);
        check("sb_wdata", dmem.wdata, 32'hA5A5_A5A5);
        check("sb_addr", dmem.addr, 32'h1000);
        check("sb_stall", {31'd0, stall_MEM}, 32'd0);
        tick();
        dmem.gnt = 1'b0;
        check("sb_req_done", {31'd0, dmem.req}, 32'd0);
        check("sb_stall2", {31'd0, stall_MEM}, 32'd0);

        // LB / LBU at 0x2001
        run_load(3'b000, "lb", 32'hFFFF_FF80);
        run_load(3'b100, "lbu", 32'h0000_0080);

        // SW then LW back-to-back, zero-wait memory
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h100, 32'hDEAD_BEEF);
        dmem.gnt = 1'b1;
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd9, 32'h104, 32'd0);
        #1;
        check("sw_req", {31'd0, dmem.req}, 32'd1);
        check("sw_we", {31'd0, dmem.we}, 32'd1);
        check("sw_be", {28'd0, dmem.be}, 32'hF);
        check("sw_wdata", dmem.wdata, 32'hDEAD_BEEF);
        check("sw_aluM", alu_result_MEM, 32'h100);
        check("sw_stall", {31'd0, stall_MEM}, 32'd0);
        tick();
        nop();
        #1;
        check("lw_req", {31'd0, dmem.req}, 32'd1);
        check("lw_we", {31'd0, dmem.we}, 32'd0);
        check("lw_addr", dmem.addr, 32'h104);
        check("lw_aluM", alu_result_MEM, 32'h104);
        check("lw_rdM", {27'd0, rd_MEM}, 32'd9);
        check("lw_stall", {31'd0, stall_MEM}, 32'd1);
        tick();
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h1234_5678;
        #1;
        check("lw_resp_req", {31'd0, dmem.req}, 32'd0);
        check("lw_resp_stall", {31'd0, stall_MEM}, 32'd0);
        tick();
        dmem.rvalid = 1'b0;
        check("lw_wb", wb_data_WB, 32'h1234_5678);
        check("lw_rdwb", {27'd0, rd_WB}, 32'd9);
        check("lw_rwwb", {31'd0, reg_write_WB}, 32'd1);

        // LW at 0x3002 (misaligned)
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h3002, 32'd0);
        dmem.gnt = 1'b1;
        tick();
        nop();
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_req", {31'd0, dmem.req}, 32'd0);
        check("mis_flag", {31'd0, misalign_MEM}, 32'd1);
        check("mis_stall", {31'd0, stall_MEM}, 32'd0);
        tick();
        dmem.gnt = 1'b0;
        check("mis_vwb", {31'd0, valid_WB}, 32'd1);
        check("mis_rwwb", {31'd0, reg_write_WB}, 32'd0);
        check("mis_flag2", {31'd0, misalign_MEM}, 32'd0);
`else
        check("mis_req", {31'd0, dmem.req}, 32'd1);
        check("mis_addr", dmem.addr, 32'h3000);
        check("mis_be", {28'd0, dmem.be}, 32'hF);
        check("mis_flag", {31'd0, misalign_MEM}, 32'd0);
        tick();
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hCAFE_F00D;
        tick();
        dmem.rvalid = 1'b0;
        check("mis_wb", wb_data_WB, 32'hCAFE_F00D);
        check("mis_rwwb", {31'd0, reg_write_WB}, 32'd1);
`endif

        // Reset held two cycles while a store sits in REQ without gnt
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h40, 32'h1);
        tick();
        nop();
        #1;
        check("mr_req", {31'd0, dmem.req}, 32'd1);
        check("mr_stall", {31'd0, stall_MEM}, 32'd1);
        rst = 1'b1;
        tick();
        check("mr_req_rst", {31'd0, dmem.req}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mr_req2", {31'd0, dmem.req}, 32'd0);
        check("mr_stall2", {31'd0, stall_MEM}, 32'd0);
        check("mr_vwb", {31'd0, valid_WB}, 32'd0);
        check("mr_rwwb", {31'd0, reg_write_WB}, 32'd0);
        check("mr_rdwb", {27'd0, rd_WB}, 32'd0);
        check("mr_wbd", wb_data_WB, 32'd0);
        tick();
        check("mr_req3", {31'd0, dmem.req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
